// File: rtl/rv_pkg.sv
// Shared RV32 load/store encodings: funct3 codes, memory port widths and LSU state encoding.
// Pure definitions, no logic; also used by CPU32 decode.
package rv_pkg;

  localparam logic [2:0] F3_LOAD_LB  = 3'd0;
  localparam logic [2:0] F3_LOAD_LH  = 3'd1;
  localparam logic [2:0] F3_LOAD_LW  = 3'd2;
  localparam logic [2:0] F3_LOAD_LBU = 3'd4;
  localparam logic [2:0] F3_LOAD_LHU = 3'd5;

  localparam logic [2:0] F3_STORE_SB = 3'd0;
  localparam logic [2:0] F3_STORE_SH = 3'd1;
  localparam logic [2:0] F3_STORE_SW = 3'd2;

  localparam logic [3:0] MEM_WIDTH_IDLE = 4'd0;
  localparam logic [3:0] MEM_WIDTH_BYTE = 4'd1;
  localparam logic [3:0] MEM_WIDTH_HALF = 4'd2;
  localparam logic [3:0] MEM_WIDTH_WORD = 4'd4;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_ISSUE = 2'd1,
    LSU_WAIT  = 2'd2,
    LSU_RESP  = 2'd3
  } lsu_state_e;

  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    if (store)
      return (f3 == F3_STORE_SB) || (f3 == F3_STORE_SH) || (f3 == F3_STORE_SW);
    return (f3 == F3_LOAD_LB) || (f3 == F3_LOAD_LH) || (f3 == F3_LOAD_LW) ||
           (f3 == F3_LOAD_LBU) || (f3 == F3_LOAD_LHU);
  endfunction

  // funct3[1:0] selects the access size for both loads and stores.
  function automatic logic [3:0] f3_width(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return MEM_WIDTH_BYTE;
      2'd1:    return MEM_WIDTH_HALF;
      default: return MEM_WIDTH_WORD;
    endcase
  endfunction

endpackage

// File: rtl/rv_load_extend.sv
// Combinational sign/zero extension of right-justified load data selected by funct3.
// Zero latency, no flow control.
module rv_load_extend
  import rv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    case (funct3)
      F3_LOAD_LB:  data = {{24{raw[7]}}, raw[7:0]};
      F3_LOAD_LH:  data = {{16{raw[15]}}, raw[15:0]};
      F3_LOAD_LBU: data = {24'd0, raw[7:0]};
      F3_LOAD_LHU: data = {16'd0, raw[15:0]};
      default:     data = raw;
    endcase
  end

endmodule

// File: rtl/rv_load_store_unit.sv
// Single-outstanding load/store unit: loads respond 2 cycles after accept, stores write 1 cycle after accept; req_ready low while busy, response held until resp_ready.
// Define LSU_MISALIGN_TRAP_EN to fault on misaligned accesses instead of forcing alignment.
module rv_load_store_unit
  import rv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [4:0]        resp_rd,
  output logic [31:0]       resp_data,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_addr,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_width,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state, state_nxt;
  logic              store_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;

  logic              accept;
  logic              req_fault;
  logic [ADDR_W-1:0] req_addr_eff;
  logic [31:0]       ext_data;

  assign accept = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  always_comb begin
    misalign = 1'b0;
    case (req_funct3[1:0])
      2'd1:    misalign = req_addr[0];
      2'd2:    misalign = (req_addr[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
  end
  assign req_fault    = !f3_legal(req_store, req_funct3) || misalign;
  assign req_addr_eff = req_addr;
`else
  assign req_fault = !f3_legal(req_store, req_funct3);
  // Misaligned halfword/word accesses are silently rounded down.
  always_comb begin
    req_addr_eff = req_addr;
    case (req_funct3[1:0])
      2'd1:    req_addr_eff = {req_addr[ADDR_W-1:1], 1'b0};
      2'd2:    req_addr_eff = {req_addr[ADDR_W-1:2], 2'b00};
      default: req_addr_eff = req_addr;
    endcase
  end
`endif

  rv_load_extend u_extend (
    .funct3 (f3_q),
    .raw    (mem_rdata),
    .data   (ext_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= LSU_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_address = '0;
    mem_width   = MEM_WIDTH_IDLE;
    mem_write   = 1'b0;
    mem_wdata   = 32'd0;
    case (state)
      LSU_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !req_fault) state_nxt = LSU_ISSUE;
      end
      LSU_ISSUE: begin
        mem_address = addr_q;
        mem_width   = f3_width(f3_q);
        mem_write   = store_q;
        case (f3_q[1:0])
          2'd0:    mem_wdata = {24'd0, wdata_q[7:0]};
          2'd1:    mem_wdata = {16'd0, wdata_q[15:0]};
          default: mem_wdata = wdata_q;
        endcase
        state_nxt = store_q ? LSU_IDLE : LSU_WAIT;
      end
      LSU_WAIT: state_nxt = LSU_RESP;
      LSU_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = LSU_IDLE;
      end
      default: state_nxt = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      store_q    <= 1'b0;
      f3_q       <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      rd_q       <= 5'd0;
      resp_rd    <= 5'd0;
      resp_data  <= 32'd0;
      fault      <= 1'b0;
      fault_addr <= '0;
    end else begin
      if (accept) begin
        store_q <= req_store;
        f3_q    <= req_funct3;
        addr_q  <= req_addr_eff;
        wdata_q <= req_wdata;
        rd_q    <= req_rd;
        fault   <= req_fault;
        if (req_fault) fault_addr <= req_addr;
      end
      // Memory data is valid only during WAIT; capture it so RESP can hold it.
      if (state == LSU_WAIT) begin
        resp_data <= ext_data;
        resp_rd   <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_rv_load_store_unit.sv
// Bench for rv_load_store_unit: byte-addressed memory model, directed requests, response scoreboard.
module tb_rv_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] mem_address;
  logic [3:0]  mem_width;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  rv_load_store_unit #(.ADDR_W(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd), .resp_data(resp_data),
    .fault(fault), .fault_addr(fault_addr),
    .mem_address(mem_address), .mem_width(mem_width), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: synchronous 1-cycle read, writes only the addressed bytes.
  logic [7:0]  mem [0:255];
  logic [31:0] rd_tmp;
  logic [31:0] last_addr = 32'd0;
  int          mem_ops = 0;

  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

  always @(posedge clock) begin
    if (mem_width != 4'd0) begin
      mem_ops   <= mem_ops + 1;
      last_addr <= mem_address;
      if (mem_write) begin
        for (int i = 0; i < 4; i++)
          if (i < int'(mem_width)) mem[8'(mem_address[7:0] + 8'(i))] <= mem_wdata[8*i +: 8];
        mem_rdata <= 32'd0;
      end else begin
        for (int i = 0; i < 4; i++)
          rd_tmp[8*i +: 8] = (i < int'(mem_width)) ? mem[8'(mem_address[7:0] + 8'(i))] : 8'h00;
        mem_rdata <= rd_tmp;
      end
    end else begin
      mem_rdata <= 32'd0;
    end
  end

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {mem[8'(a + 8'd3)], mem[8'(a + 8'd2)], mem[8'(a + 8'd1)], mem[a]};
  endfunction

  // Scoreboard
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    time         t;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic prev_valid = 1'b0;

  always @(negedge clock) begin
    if (!reset) begin
      if (resp_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected resp_valid: got 1, expected 0");
        end else begin
          // first sampled valid: accept edge + 2 cycles + half cycle
          check("resp latency", 32'($time - sb[0].t), 32'd25);
        end
      end
      if (resp_valid && resp_ready && sb.size() != 0) begin
        e = sb.pop_front();
        check("resp_data", resp_data, e.data);
        check("resp_rd", 32'(resp_rd), 32'(e.rd));
      end
    end
    prev_valid = resp_valid;
  end

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input bit expect_resp, input logic [31:0] exp_data, output int waits);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_rd     = rd;
    waits = 0;
    @(negedge clock);
    while (!req_ready && waits < 50) begin
      waits++;
      @(negedge clock);
    end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept timeout: req_ready got 0, expected 1");
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    if (expect_resp) sb.push_back('{rd, exp_data, $time});
    #1 req_valid = 1'b0;
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                    input logic [31:0] exp_data);
    int w;
    issue(1'b0, f3, a, 32'd0, rd, 1'b1, exp_data, w);
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_addr, input logic [3:0] exp_w,
                          input logic [31:0] exp_wd);
    int w;
    issue(1'b1, f3, a, wd, 5'd0, 1'b0, 32'd0, w);
    check("store mem_address", mem_address, exp_addr);
    check("store mem_width", 32'(mem_width), 32'(exp_w));
    check("store mem_write", 32'(mem_write), 32'd1);
    check("store mem_wdata", mem_wdata, exp_wd);
    @(posedge clock); #1;
    check("store req_ready after", 32'(req_ready), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((!req_ready || sb.size() != 0) && n < 100) begin
      n++;
      @(posedge clock); #1;
    end
    if (n >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL idle timeout: req_ready got %0d, expected 1", req_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int snap;

    repeat (2) @(posedge clock);
    #1;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_rd", 32'(resp_rd), 32'd0);
    check("reset resp_data", resp_data, 32'd0);
    check("reset fault", 32'(fault), 32'd0);
    check("reset fault_addr", fault_addr, 32'd0);
    check("reset mem_bus", {mem_address[27:0], mem_width}, 32'd0);
    check("reset mem_write/wdata", mem_wdata | 32'(mem_write), 32'd0);
    #1 reset = 1'b0;
    @(posedge clock); #1;

    // SW then loads of every width
    do_store(3'd2, 32'h80, 32'h8899AABB, 32'h80, 4'd4, 32'h8899AABB);
    check("mem word 0x80 after SW", mem_word(8'h80), 32'h8899AABB);
    ld(3'd2, 32'h80, 5'd5,  32'h8899AABB);
    ld(3'd0, 32'h81, 5'd6,  32'hFFFFFFAA);
    ld(3'd4, 32'h81, 5'd7,  32'h000000AA);
    ld(3'd1, 32'h82, 5'd8,  32'hFFFF8899);
    ld(3'd5, 32'h80, 5'd31, 32'h0000AABB);
    wait_idle();

    // SB touches one lane; SH masks upper data
    do_store(3'd0, 32'h83, 32'h00000012, 32'h83, 4'd1, 32'h00000012);
    check("mem word 0x80 after SB", mem_word(8'h80), 32'h1299AABB);
    do_store(3'd1, 32'h84, 32'hFFFF5566, 32'h84, 4'd2, 32'h00005566);
    check("mem word 0x84 after SH", mem_word(8'h84), 32'h00005566);
    ld(3'd2, 32'h80, 5'd10, 32'h1299AABB);
    ld(3'd2, 32'h84, 5'd11, 32'h00005566);
    wait_idle();

    // Illegal funct3: fault, no access, no response
    snap = mem_ops;
    issue(1'b0, 3'd3, 32'h80, 32'd0, 5'd12, 1'b0, 32'd0, w);
    check("illegal load fault", 32'(fault), 32'd1);
    check("illegal load fault_addr", fault_addr, 32'h80);
    check("illegal load req_ready", 32'(req_ready), 32'd1);
    issue(1'b1, 3'd5, 32'h88, 32'h11223344, 5'd0, 1'b0, 32'd0, w);
    check("illegal store fault_addr", fault_addr, 32'h88);
    repeat (3) @(posedge clock);
    #1;
    check("illegal no mem access", 32'(mem_ops - snap), 32'd0);
    check("illegal store no write", mem_word(8'h88), 32'd0);
    ld(3'd2, 32'h80, 5'd1, 32'h1299AABB);
    check("legal accept clears fault", 32'(fault), 32'd0);
    wait_idle();

    // Misaligned word
`ifdef LSU_MISALIGN_TRAP_EN
    snap = mem_ops;
    issue(1'b0, 3'd2, 32'h86, 32'd0, 5'd3, 1'b0, 32'd0, w);
    check("misalign fault", 32'(fault), 32'd1);
    check("misalign fault_addr", fault_addr, 32'h86);
    repeat (4) @(posedge clock);
    #1;
    check("misalign no mem access", 32'(mem_ops - snap), 32'd0);
    check("misalign resp_valid", 32'(resp_valid), 32'd0);
`else
    ld(3'd2, 32'h86, 5'd3, 32'h00005566);
    wait_idle();
    check("misalign aligned address", last_addr, 32'h84);
    check("misalign no fault", 32'(fault), 32'd0);
`endif

    // Response held under backpressure; rd=0 still responds
    resp_ready = 1'b0;
    ld(3'd2, 32'h80, 5'd0, 32'h1299AABB);
    for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clock);
    req_valid = 1'b1;
    req_funct3 = 3'd5;
    req_addr = 32'h82;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("hold resp_valid", 32'(resp_valid), 32'd1);
      check("hold resp_data", resp_data, 32'h1299AABB);
      check("hold resp_rd", 32'(resp_rd), 32'd0);
      check("hold req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clock); #1;
    resp_ready = 1'b1;
    issue(1'b0, 3'd5, 32'h82, 32'd0, 5'd9, 1'b1, 32'h00001299, w);
    check("bubble before next accept", 32'(w), 32'd1);
    wait_idle();

    // Reset during WAIT drops the load
    issue(1'b0, 3'd2, 32'h80, 32'd0, 5'd7, 1'b0, 32'd0, w);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("rst-wait resp_valid", 32'(resp_valid), 32'd0);
    check("rst-wait req_ready", 32'(req_ready), 32'd1);
    check("rst-wait mem_bus", {mem_address[27:0], mem_width}, 32'd0);
    check("rst-wait mem_write/wdata", mem_wdata | 32'(mem_write), 32'd0);
    check("rst-wait resp_data", resp_data, 32'd0);
    @(posedge clock); #2 reset = 1'b0;

    // Reset held while a SW is presented: nothing written
    snap = mem_ops;
    reset = 1'b1;
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h90; req_wdata = 32'hDEADBEEF;
    repeat (3) @(posedge clock);
    #1 req_valid = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst-idle SW no write", mem_word(8'h90), 32'd0);
    check("rst-idle no mem access", 32'(mem_ops - snap), 32'd0);

    ld(3'd4, 32'h83, 5'd4, 32'h00000012);
    wait_idle();
    repeat (5) @(posedge clock);
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
